// File: rtl/dm_access_ctrl.sv
// Load/store controller between the MEM stage and a word-wide data memory.
// Handles byte/halfword/word accesses, checks alignment and range, extends
// load data and performs read-modify-write for sub-word stores.
module dm_access_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              addr_err,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_din,
  input  logic [31:0]       dm_dout
);

  typedef enum logic [2:0] {IDLE, RD, WR, RESP, ERR} state_t;

  state_t      state;
  logic [1:0]  lo_q;
  logic [1:0]  size_q;
  logic        wr_q;
  logic        uns_q;
  logic [31:0] wdata_q;

  logic misalign;
  logic out_of_range;

  // Select the addressed lane of a memory word and extend it to 32 bits.
  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] lo, input logic u);
    logic [31:0] s;
    load_ext = w;
    case (sz)
      2'b00: begin
        s = w >> {lo, 3'b000};
        load_ext = u ? {24'h0, s[7:0]} : {{24{s[7]}}, s[7:0]};
      end
      2'b01: begin
        s = w >> {lo[1], 4'b0000};
        load_ext = u ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
      end
      default: load_ext = w;
    endcase
  endfunction

  // Overlay right-justified store data onto the addressed lanes of a word.
  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] d,
                                              input logic [1:0] sz, input logic [1:0] lo);
    logic [31:0] mask;
    store_merge = d;
    case (sz)
      2'b00: begin
        mask = 32'h0000_00FF << {lo, 3'b000};
        store_merge = (w & ~mask) | ((d & 32'h0000_00FF) << {lo, 3'b000});
      end
      2'b01: begin
        mask = 32'h0000_FFFF << {lo[1], 4'b0000};
        store_merge = (w & ~mask) | ((d & 32'h0000_FFFF) << {lo[1], 4'b0000});
      end
      default: store_merge = d;
    endcase
  endfunction

  // Size 11 behaves as a word, so any size with bit 1 set needs full alignment.
  assign misalign     = (size == 2'b01 && addr[0]) || (size[1] && addr[1:0] != 2'b00);
  assign out_of_range = |addr[31:ADDR_W];

  // Access sequencer; every output is registered and set on entry to its state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ready    <= 1'b1;
      done     <= 1'b0;
      addr_err <= 1'b0;
      rdata    <= 32'h0;
      dm_we    <= 1'b0;
      dm_addr  <= '0;
      dm_din   <= 32'h0;
    end else begin
      done     <= 1'b0;
      addr_err <= 1'b0;
      dm_we    <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            lo_q    <= addr[1:0];
            size_q  <= size;
            wr_q    <= wr;
            uns_q   <= uns;
            wdata_q <= wdata;
            dm_addr <= {addr[ADDR_W-1:2], 2'b00};
            ready   <= 1'b0;
            if (misalign || out_of_range) begin
              state    <= ERR;
              done     <= 1'b1;
              addr_err <= 1'b1;
            end else if (wr && size[1]) begin
              state  <= WR;
              dm_we  <= 1'b1;
              dm_din <= wdata;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          // dm_dout is sampled here; this edge is the read-buffer capture.
          if (wr_q) begin
            state  <= WR;
            dm_we  <= 1'b1;
            dm_din <= store_merge(dm_dout, wdata_q, size_q, lo_q);
          end else begin
            state <= RESP;
            done  <= 1'b1;
            rdata <= load_ext(dm_dout, size_q, lo_q, uns_q);
          end
        end
        WR: begin
          state <= RESP;
          done  <= 1'b1;
        end
        RESP, ERR: begin
          state <= IDLE;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Bench for dm_access_ctrl: a word memory attached to the memory port and a
// byte-array reference model that predicts latency, writes and load results.
module tb_dm_access_ctrl;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset, req, wr, uns;
  logic [1:0]        size;
  logic [31:0]       addr, wdata;
  logic              ready, done, addr_err, dm_we;
  logic [31:0]       rdata, dm_din, dm_dout;
  logic [ADDR_W-1:0] dm_addr;

  logic [31:0] mem  [256];
  logic [7:0]  refm [1024];
  logic [31:0] ref_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dm_access_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .ready(ready), .done(done), .rdata(rdata),
    .addr_err(addr_err), .dm_we(dm_we), .dm_addr(dm_addr), .dm_din(dm_din),
    .dm_dout(dm_dout)
  );

  assign dm_dout = mem[dm_addr[ADDR_W-1:2]];

  always @(posedge clk) begin
    if (dm_we) mem[dm_addr[ADDR_W-1:2]] <= dm_din;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access: predict from the byte model, drive, observe until done.
  task automatic access(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d, input bit hold);
    int n, lat, expwe, wecyc, base, done_cyc, we_cnt, we_cyc;
    logic err;
    logic [31:0] v, expdin, eaddr, we_addr, we_din, sig;
    logic aerr;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    err = (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00) || (a >= 32'd1024);
    expwe = 0; wecyc = 0; expdin = 0; lat = 2;
    eaddr = {22'h0, a[9:2], 2'b00};
    base = int'(a[9:0]);
    if (err) begin
      lat = 1;
    end else if (w) begin
      for (int i = 0; i < n; i++) begin
        v = d >> (8 * i);
        refm[base + i] = v[7:0];
      end
      expdin = {refm[int'(eaddr) + 3], refm[int'(eaddr) + 2],
                refm[int'(eaddr) + 1], refm[int'(eaddr)]};
      expwe = 1;
      lat = (n == 4) ? 2 : 3;
      wecyc = lat - 1;
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v = v | (32'(refm[base + i]) << (8 * i));
      if (!u && n < 4) begin
        sig = v >> (8 * n - 1);
        if (sig[0]) v = v | (32'hFFFF_FFFF << (8 * n));
      end
      ref_rdata = v;
      lat = 2;
    end

    @(negedge clk);
    for (int k = 0; k < 10 && ready !== 1'b1; k++) @(negedge clk);
    check("ready_before_req", {31'h0, ready}, 32'h1);
    req = 1'b1; wr = w; size = sz; uns = u; addr = a; wdata = d;
    @(posedge clk);
    done_cyc = 0; we_cnt = 0; we_cyc = 0; we_addr = 0; we_din = 0; aerr = 1'bx;
    for (int cyc = 1; cyc <= 6 && done_cyc == 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1 && !hold) begin
        req = 1'b0; addr = $urandom; wdata = $urandom; uns = 1'($urandom);
        size = 2'($urandom); wr = 1'($urandom);
      end
      if (dm_we === 1'b1) begin
        we_cnt++; we_cyc = cyc; we_addr = 32'(dm_addr); we_din = dm_din;
      end
      if (done === 1'b1) begin
        done_cyc = cyc; aerr = addr_err;
      end
    end
    check("done_latency", done_cyc, lat);
    check("addr_err", {31'h0, aerr}, {31'h0, err});
    check("write_count", we_cnt, expwe);
    if (expwe == 1) begin
      check("write_cycle", we_cyc, wecyc);
      check("write_addr", we_addr, eaddr);
      check("write_data", we_din, expdin);
    end
    check("rdata", rdata, ref_rdata);
  endtask

  initial begin
    int bad;
    logic [31:0] a;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    for (int i = 0; i < 1024; i++) refm[i] = 8'h0;
    ref_rdata = 32'h0;
    reset = 1'b1; req = 1'b0; wr = 1'b0; size = 2'b00; uns = 1'b0;
    addr = 32'h0; wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'h0, ready}, 32'h1);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_addr_err", {31'h0, addr_err}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_dm_we", {31'h0, dm_we}, 32'h0);
    check("rst_dm_addr", 32'(dm_addr), 32'h0);
    check("rst_dm_din", dm_din, 32'h0);
    reset = 1'b0;

    // Word store then word load.
    access(1'b1, 2'b10, 1'b0, 32'h010, 32'hDEADBEEF, 1'b0);
    access(1'b0, 2'b10, 1'b0, 32'h010, 32'h0, 1'b0);
    check("tp1_word_load", rdata, 32'hDEADBEEF);

    // Byte store via read-modify-write.
    access(1'b1, 2'b00, 1'b0, 32'h013, 32'h000000A5, 1'b0);
    check("tp2_mem_word", mem[4], 32'hA5ADBEEF);

    // Extended loads.
    access(1'b0, 2'b00, 1'b0, 32'h013, 32'h0, 1'b0);
    check("tp3_byte_signed", rdata, 32'hFFFFFFA5);
    access(1'b0, 2'b00, 1'b1, 32'h013, 32'h0, 1'b0);
    check("tp3_byte_unsigned", rdata, 32'h000000A5);
    access(1'b0, 2'b01, 1'b0, 32'h012, 32'h0, 1'b0);
    check("tp3_half_signed", rdata, 32'hFFFFA5AD);
    access(1'b0, 2'b01, 1'b1, 32'h010, 32'h0, 1'b0);
    check("tp3_half_unsigned", rdata, 32'h0000BEEF);

    // Error accesses.
    access(1'b0, 2'b10, 1'b0, 32'h012, 32'h0, 1'b0);
    access(1'b1, 2'b01, 1'b0, 32'h011, 32'h1234, 1'b0);
    access(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 1'b0);
    check("tp4_rdata_kept", rdata, 32'h0000BEEF);
    check("tp4_mem_kept", mem[4], 32'hA5ADBEEF);

    // Reset during the read phase of a byte store.
    access(1'b1, 2'b10, 1'b0, 32'h010, 32'h11223344, 1'b0);
    @(negedge clk);
    req = 1'b1; wr = 1'b1; size = 2'b00; addr = 32'h010; wdata = 32'h77;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    check("tp5_rd_no_we", {31'h0, dm_we}, 32'h0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    ref_rdata = 32'h0;
    check("tp5_ready", {31'h0, ready}, 32'h1);
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      if (dm_we !== 1'b0 || done !== 1'b0) bad++;
      @(negedge clk);
    end
    check("tp5_quiet_after_reset", bad, 0);
    check("tp5_rdata_reset", rdata, 32'h0);
    access(1'b0, 2'b10, 1'b0, 32'h010, 32'h0, 1'b0);
    check("tp5_word_unchanged", rdata, 32'h11223344);

    // req held through a halfword store.
    access(1'b1, 2'b01, 1'b0, 32'h022, 32'h0000CAFE, 1'b1);
    @(negedge clk);
    check("tp6_ready_after_done", {31'h0, ready}, 32'h1);
    @(negedge clk);
    check("tp6_accepted", {31'h0, ready}, 32'h0);
    req = 1'b0;
    bad = 1;
    for (int k = 0; k < 6 && bad != 0; k++) begin
      if (done === 1'b1) bad = 0;
      else @(negedge clk);
    end
    check("tp6_second_done", bad, 0);

    // Randomized accesses against the byte model.
    for (int t = 0; t < 60; t++) begin
      a = ($urandom_range(0, 9) == 0) ? ($urandom_range(1024, 1100)) : $urandom_range(0, 1023);
      access(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, 1'b0);
    end

    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (mem[i] !== {refm[4*i+3], refm[4*i+2], refm[4*i+1], refm[4*i]}) bad++;
    end
    check("memory_image", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
Load/store controller between the MIPS MEM stage and the word-wide data memory. It accepts one byte, halfword or word access per handshake and checks alignment and range. Loads return sign- or zero-extended data. Sub-word stores use read-modify-write, because the memory always writes a full aligned 32-bit word.

Parameters:
ADDR_W, 10, byte-address width of the data memory (capacity 2^ADDR_W bytes)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
req  input  1  access request, sampled only while ready=1
wr  input  1  1=store, 0=load
size  input  2  00=byte, 01=halfword, 10=word; 11 is treated as word
uns  input  1  load zero-extends when 1, sign-extends when 0
addr  input  32  byte address
wdata  input  32  store data, right-justified
ready  output  1  controller idle, can accept req
done  output  1  one-cycle completion pulse
rdata  output  32  load result, valid from done and held until the next done
addr_err  output  1  valid with done: access was misaligned or out of range
dm_we  output  1  memory write enable
dm_addr  output  ADDR_W  word-aligned byte address to the memory, low 2 bits always 0
dm_din  output  32  memory write data
dm_dout  input  32  memory combinational read data, little-endian (byte k at bits 8k+7:8k)

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on reset; polarity and synchronicity are fixed.
- States: IDLE, RD, WR, RESP, ERR.
- ready=1 only in IDLE.
- Reset values: state=IDLE, ready=1, done=0, addr_err=0, rdata=0, dm_we=0, dm_addr=0, dm_din=0.
- Reset in any state: return to IDLE at that edge. No write is issued, done does not pulse, and the latched request is discarded.
- IDLE with req=1: latch addr, size, wr, uns and wdata. Next state:
  - ERR if misaligned (halfword with addr[0]=1, word with addr[1:0]!=0) or out of range (addr[31:ADDR_W]!=0);
  - WR for a word store;
  - RD otherwise.
- req while ready=0 is ignored. There is no queue.
- RD: drive dm_addr = {latched addr[ADDR_W-1:2], 2'b00} and capture dm_dout into the read buffer. Go to RESP for loads, WR for sub-word stores.
- WR: dm_we=1 for exactly this one cycle, with dm_addr aligned as in RD, then go to RESP. dm_din is:
  - word store: wdata;
  - byte store: read buffer with lane addr[1:0] replaced by wdata[7:0];
  - halfword store: read buffer with lanes {addr[1],1}:{addr[1],0} replaced by wdata[15:0].
- RESP: done=1, addr_err=0, then go to IDLE.
  - Loads: rdata = selected lane of the read buffer, extended to 32 bits by uns (sign bit 7 for byte, 15 for halfword).
  - Stores: rdata unchanged.
- ERR: done=1 and addr_err=1 for one cycle, dm_we never asserted, rdata unchanged, then go to IDLE.
- dm_we=0 in every state except WR.
- Latency from the req-accept edge T:
  - load: done in cycle T+2;
  - word store: write at T+1, done at T+2;
  - sub-word store: read at T+1, write at T+2, done at T+3;
  - error: done at T+1.
- Back-to-back: a req in the cycle after done (IDLE again) is accepted. Throughput is at most one access per 3 cycles.
- Unused address bits addr[1:0] of the aligned word address are never passed to dm_addr.

Test Plan:
1. Reset 2 cycles, then word store 0xDEADBEEF at 0x010. Required: dm_we=1 only at T+1 with dm_addr=0x010 and dm_din=0xDEADBEEF; done at T+2 with addr_err=0. A following word load from 0x010 gives rdata=0xDEADBEEF at its T+2.
2. Byte store wdata=0x000000A5 at 0x013 over 0xDEADBEEF. Required: RD at T+1 with dm_we=0; WR at T+2 with dm_din=0xA5ADBEEF; done at T+3.
3. Loads after scenario 2:
   - byte 0x013, uns=0 -> 0xFFFFFFA5;
   - byte 0x013, uns=1 -> 0x000000A5;
   - half 0x012, uns=0 -> 0xFFFFA5AD;
   - half 0x010, uns=1 -> 0x0000BEEF.
4. Error accesses: word load 0x012, half store 0x011, word load 0x400. Required for each: done=1 and addr_err=1 at T+1, dm_we never high, memory unchanged, rdata unchanged.
5. Reset asserted in the RD cycle of a byte store to 0x010. Required: no dm_we, no done, ready=1 the next cycle, and a word at 0x010 written beforehand reads back unchanged.
6. req held high through a sub-word store. Required: exactly one write, exactly one done, and the next request accepted the cycle after done.
